cir_col_feeder: RTL and testbench
=================================

Name: cir_col_feeder

Overview:
- Producer side of the convolution window register. Reads the input feature map from byte-wide SRAM, one byte per read, with 1-cycle read latency.
- Assembles K_H-tall columns and drives the window register's load_en, clear and in_data.
- Walks the image in row bands (stride 1), pulsing clear at each band start and flagging when a full K_H x K_W window is present.
- Sits between the feature-map SRAM and the PE window register.

Parameters:
K_H, 3, kernel height = column height
K_W, 3, kernel width; window full after K_W loads in a band
IMG_H, 8, feature map rows (IMG_H >= K_H)
IMG_W, 8, feature map columns (IMG_W >= K_W)
ADDR_W, 16, SRAM address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  begin traversal; sampled only in IDLE
hold  in  1  downstream stall; blocks load_en
mem_rd_en  out  1  SRAM read strobe
mem_addr  out  ADDR_W  SRAM byte address = row*IMG_W + col
mem_rdata  in  8  read data, valid cycle after mem_rd_en
load_en  out  1  shift col_data into window register
clear  out  1  zero window register
col_data  out  8 x [0:K_H-1]  column; index k = image row r0+k
win_valid  out  1  window register holds full window
win_row  out  ADDR_W  top row of current window
win_col  out  ADDR_W  left column of current window
busy  out  1  high when not IDLE
done  out  1  one-cycle pulse at traversal end

Behaviour:
- Reset (async, rst=1): state IDLE; all counters zero; col_buf zero; every output 0. Reset mid-traversal aborts without a done pulse.
- Counters:
  - r0: band top row, 0..IMG_H-K_H.
  - c: column, 0..IMG_W-1.
  - k: read index, 0..K_H-1.
- FSM:
  - IDLE: start=1 -> CLR.
  - CLR (1 cycle): clear=1; c=0, k=0 -> FETCH.
  - FETCH (K_H cycles): mem_rd_en=1, mem_addr=(r0+k)*IMG_W+c, k++. Then k=0 -> WAIT.
  - WAIT (1 cycle): captures the last read byte.
  - LOAD: if hold=0: load_en=1 for that cycle, then advance.
    - If c<IMG_W-1: c++, go to FETCH.
    - Else if r0<IMG_H-K_H: r0++, go to CLR.
    - Else go to FIN.
  - LOAD with hold=1: stays in LOAD with load_en=0; col_data stable.
  - FIN (1 cycle): done=1 -> IDLE.
- Read capture: the byte returned in the cycle after a read with index k is registered into col_buf[k]. col_data = col_buf (registered, stable through LOAD).
- Timing: per column K_H+2 cycles when hold=0; per band 1+IMG_W*(K_H+2).
- win_valid is registered. It is high for exactly the cycle after a load_en whose c >= K_W-1. In that cycle win_row=r0 of that load and win_col=c-(K_W-1). Otherwise win_valid=0 and win_row/win_col hold their last values.
- clear and load_en are never high in the same cycle.
- start while busy is ignored; hold outside LOAD has no effect.
- Address arithmetic is in ADDR_W bits; IMG_H*IMG_W must fit in ADDR_W (elaboration-time assertion).

Test Plan:
- IMG_H=4, IMG_W=5, K 3x3, memory[a]=a, no hold -> read sequence 0,5,10,1,6,11,...; band1 column 0 reads 5,10,15. 10 load_en pulses; col_data at first load = {0,5,10}. done asserted 53 cycles after the start-sampling cycle.
- Same config -> clear high once before each band (2 pulses). win_valid pulses 6 times with (win_row,win_col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
- hold=1 for 4 cycles on entering the first LOAD -> load_en delayed 4 cycles; col_data unchanged throughout; total cycles +4; no extra or missed reads.
- start pulsed again mid-traversal -> ignored; addresses and done timing identical to the no-repeat run.
- rst asserted during band 0 FETCH -> outputs 0 in the same cycle (async), state IDLE. A subsequent start restarts at address 0 with a fresh clear.
- IMG_H=K_H=3, IMG_W=K_W=3 -> single band, 3 loads, exactly one win_valid pulse at (0,0), done 1+3*5+1=17 cycles after start.

Source files
------------

// File: rtl/cir_col_feeder_if.sv
// rtl/cir_col_feeder_if.sv - SRAM read port and window-register load port of the column feeder
`timescale 1ns/1ps
interface cir_col_feeder_if #(
  parameter int K_H    = 3,
  parameter int ADDR_W = 16
);
  logic                   mem_rd_en;
  logic [ADDR_W-1:0]      mem_addr;
  logic [7:0]             mem_rdata;
  logic                   hold;
  logic                   load_en;
  logic                   clear;
  logic [0:K_H-1][7:0]    col_data;
  logic                   win_valid;
  logic [ADDR_W-1:0]      win_row;
  logic [ADDR_W-1:0]      win_col;

  modport master (
    output mem_rd_en, mem_addr, load_en, clear, col_data, win_valid, win_row, win_col,
    input  mem_rdata, hold
  );

  modport slave (
    input  mem_rd_en, mem_addr, load_en, clear, col_data, win_valid, win_row, win_col,
    output mem_rdata, hold
  );
endinterface

// File: rtl/cir_col_feeder.sv
// rtl/cir_col_feeder.sv - fetches K_H-tall feature-map columns and feeds the window register
`timescale 1ns/1ps
module cir_col_feeder #(
  parameter int K_H    = 3,
  parameter int K_W    = 3,
  parameter int IMG_H  = 8,
  parameter int IMG_W  = 8,
  parameter int ADDR_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  cir_col_feeder_if.master bus
);

  localparam int KB = (K_H > 1) ? $clog2(K_H) : 1;
  localparam logic [KB-1:0]     K_LAST  = KB'(K_H - 1);
  localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] R_LAST  = ADDR_W'(IMG_H - K_H);
  localparam logic [ADDR_W-1:0] W_SPAN  = ADDR_W'(K_W - 1);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  // The whole image must be byte-addressable within ADDR_W bits.
  if (64'(IMG_H) * 64'(IMG_W) > (64'd1 << ADDR_W)) begin : g_addr_too_narrow
    $error("cir_col_feeder: IMG_H*IMG_W does not fit in ADDR_W bits");
  end
  if (IMG_H < K_H || IMG_W < K_W) begin : g_image_too_small
    $error("cir_col_feeder: image smaller than kernel");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_WAIT,
    S_LOAD,
    S_FIN
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [ADDR_W-1:0]    r0;
  logic [ADDR_W-1:0]    c;
  logic [KB-1:0]        k;
  logic                 rd_pend;
  logic [KB-1:0]        rd_idx;
  logic [0:K_H-1][7:0]  col_buf;
  logic [ADDR_W-1:0]    row_idx;
  logic                 load_fire;

  assign row_idx      = r0 + ADDR_W'(k);
  assign load_fire    = (state == S_LOAD) && !bus.hold;
  assign bus.col_data = col_buf;

  // State register; reset aborts any traversal without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and the strobes that depend only on the current state.
  always_comb begin
    state_nxt     = state;
    bus.mem_rd_en = 1'b0;
    bus.mem_addr  = '0;
    bus.clear     = 1'b0;
    bus.load_en   = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_CLR;
      end
      S_CLR: begin
        bus.clear = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        bus.mem_rd_en = 1'b1;
        bus.mem_addr  = row_idx * IMG_W_A + c;
        if (k == K_LAST) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (!bus.hold) begin
          bus.load_en = 1'b1;
          if (c != C_LAST)       state_nxt = S_FETCH;
          else if (r0 != R_LAST) state_nxt = S_CLR;
          else                   state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Band/column/read-index counters advance alongside the state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0 <= '0;
      c  <= '0;
      k  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) r0 <= '0;
        S_CLR: begin
          c <= '0;
          k <= '0;
        end
        S_FETCH: k <= (k == K_LAST) ? '0 : k + KB'(1);
        S_LOAD: begin
          if (!bus.hold) begin
            if (c != C_LAST)       c  <= c + ADDR_W'(1);
            else if (r0 != R_LAST) r0 <= r0 + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // SRAM data arrives one cycle after the strobe; steer it into the slot of the row it was read for.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_idx  <= '0;
      col_buf <= '0;
    end else begin
      rd_pend <= (state == S_FETCH);
      rd_idx  <= k;
      if (rd_pend) col_buf[rd_idx] <= bus.mem_rdata;
    end
  end

  // Flag a full window the cycle after the K_W-th (or later) column of a band is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.win_valid <= 1'b0;
      bus.win_row   <= '0;
      bus.win_col   <= '0;
    end else begin
      bus.win_valid <= 1'b0;
      if (load_fire && c >= W_SPAN) begin
        bus.win_valid <= 1'b1;
        bus.win_row   <= r0;
        bus.win_col   <= c - W_SPAN;
      end
    end
  end

endmodule

// File: tb/tb_cir_col_feeder.sv
// tb/tb_cir_col_feeder.sv - scoreboard bench for cir_col_feeder on a 4x5 and a 3x3 image
`timescale 1ns/1ps
module tb_cir_col_feeder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic hold = 1'b0;
  logic busy_a, done_a, busy_b, done_b;

  cir_col_feeder_if #(.K_H(3), .ADDR_W(16)) ifa ();
  cir_col_feeder_if #(.K_H(3), .ADDR_W(16)) ifb ();

  cir_col_feeder #(.K_H(3), .K_W(3), .IMG_H(4), .IMG_W(5), .ADDR_W(16)) dut_a (
    .clk   (clk),
    .rst   (rst),
    .start (start_a),
    .busy  (busy_a),
    .done  (done_a),
    .bus   (ifa)
  );

  cir_col_feeder #(.K_H(3), .K_W(3), .IMG_H(3), .IMG_W(3), .ADDR_W(16)) dut_b (
    .clk   (clk),
    .rst   (rst),
    .start (start_b),
    .busy  (busy_b),
    .done  (done_b),
    .bus   (ifb)
  );

  always #5 clk = ~clk;

  assign ifa.hold = hold;
  assign ifb.hold = 1'b0;

  // SRAM model: memory[a] = a, one-cycle read latency.
  always @(posedge clk) begin
    ifa.mem_rdata <= ifa.mem_rd_en ? ifa.mem_addr[7:0] : 8'hEE;
    ifb.mem_rdata <= ifb.mem_rd_en ? ifb.mem_addr[7:0] : 8'hEE;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int clr_cnt = 0;
  int done_seen = 0;
  int done_cyc = 0;
  bit sel = 1'b0;

  logic [15:0] q_addr[$];
  logic [23:0] q_col[$];
  logic [31:0] q_win[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int h, input int w);
    for (int r = 0; r <= h - 3; r++) begin
      for (int c = 0; c < w; c++) begin
        for (int k = 0; k < 3; k++) q_addr.push_back(16'((r + k) * w + c));
        q_col.push_back({8'(r * w + c), 8'((r + 1) * w + c), 8'((r + 2) * w + c)});
        if (c >= 2) q_win.push_back({16'(r), 16'(c - 2)});
      end
    end
  endtask

  task automatic flush_exp();
    q_addr.delete();
    q_col.delete();
    q_win.delete();
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_rd_en"},  ifa.mem_rd_en, 0);
    check({tag, "_addr"},   ifa.mem_addr, 0);
    check({tag, "_clear"},  ifa.clear, 0);
    check({tag, "_load"},   ifa.load_en, 0);
    check({tag, "_col"},    ifa.col_data, 0);
    check({tag, "_wvalid"}, ifa.win_valid, 0);
    check({tag, "_wrow"},   ifa.win_row, 0);
    check({tag, "_wcol"},   ifa.win_col, 0);
    check({tag, "_busy"},   busy_a, 0);
    check({tag, "_done"},   done_a, 0);
  endtask

  logic        m_rd, m_ld, m_cl, m_wv, m_dn;
  logic [15:0] m_ad, m_wr, m_wc;
  logic [23:0] m_cd;

  // Scoreboard: every read, load and window flag of the selected DUT is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      m_rd = sel ? ifb.mem_rd_en : ifa.mem_rd_en;
      m_ad = sel ? ifb.mem_addr  : ifa.mem_addr;
      m_ld = sel ? ifb.load_en   : ifa.load_en;
      m_cd = sel ? ifb.col_data  : ifa.col_data;
      m_cl = sel ? ifb.clear     : ifa.clear;
      m_wv = sel ? ifb.win_valid : ifa.win_valid;
      m_wr = sel ? ifb.win_row   : ifa.win_row;
      m_wc = sel ? ifb.win_col   : ifa.win_col;
      m_dn = sel ? done_b        : done_a;
      if (m_rd) begin
        if (q_addr.size() == 0) check("rd_extra", 1, 0);
        else check("rd_addr", m_ad, q_addr.pop_front());
      end
      if (m_ld) begin
        if (q_col.size() == 0) check("load_extra", 1, 0);
        else check("col_data", m_cd, q_col.pop_front());
      end
      if (m_wv) begin
        if (q_win.size() == 0) check("win_extra", 1, 0);
        else check("win_pos", {m_wr, m_wc}, q_win.pop_front());
      end
      if (m_cl) begin
        clr_cnt++;
        check("clr_ld_excl", m_ld, 0);
      end
      if (m_dn) begin
        done_seen++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run(input bit use_b, input bit hold_test, input bit restart,
                     input int exp_cycles, input int exp_clears);
    int ps;
    int t;
    sel = use_b;
    flush_exp();
    if (use_b) push_exp(3, 3);
    else       push_exp(4, 5);
    clr_cnt   = 0;
    done_seen = 0;
    @(posedge clk);
    #1;
    ps = cyc;
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    for (int i = 0; i < 400 && done_seen == 0; i++) begin
      @(posedge clk);
      #1;
      t = cyc - ps;
      start_a = !use_b && restart && (t == 20);
      start_b = 1'b0;
      if (hold_test) hold = (t >= 5 && t <= 9);
      @(negedge clk);
      if (hold_test && t >= 6 && t <= 10) check("hold_col_stable", ifa.col_data, 24'h00050a);
      if (hold_test && t >= 6 && t <= 9)  check("hold_no_load", ifa.load_en, 0);
    end
    hold = 1'b0;
    check("done_seen", done_seen != 0, 1);
    check("done_time", done_cyc - ps, exp_cycles);
    repeat (3) @(negedge clk);
    check("done_once", done_seen, 1);
    check("clear_cnt", clr_cnt, exp_clears);
    check("idle_busy", use_b ? busy_b : busy_a, 0);
    check("rd_left", q_addr.size(), 0);
    check("load_left", q_col.size(), 0);
    check("win_left", q_win.size(), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_zero_a("reset");
    rst = 1'b0;

    run(0, 0, 0, 53, 2);
    run(0, 1, 0, 57, 2);
    run(0, 0, 1, 53, 2);

    // Abort during band 0 FETCH with an asynchronous reset.
    sel = 1'b0;
    flush_exp();
    done_seen = 0;
    @(posedge clk);
    #1;
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    @(posedge clk);
    #2;
    check("abort_in_fetch", ifa.mem_rd_en, 1);
    rst = 1'b1;
    #1;
    check_zero_a("abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush_exp();
    repeat (3) @(negedge clk);
    check("abort_no_done", done_seen, 0);

    run(0, 0, 0, 53, 2);
    run(1, 0, 0, 17, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
